vector_alu_sequencer: RTL and testbench
=======================================

Name: vector_alu_sequencer

Overview:
- Command-side initiator for the scalar 8-bit ALU. Accepts one packed multi-lane vector operation per handshake and issues it to the ALU one lane per cycle, driving aluFunction, aluOperandA and aluOperandB.
- Captures each combinational aluResult and presents the assembled result vector on a valid/ready output.
- Sits between the instruction decode stage and the ALU datapath.

Parameters:
- BITS, 8, element width; must match the ALU's BITS.
- ALUOP, 4, function-code width; must match the ALU's ALUOP.
- LANES, 4, elements per vector.
- LENW, 3, width of cmdLength; must hold the value LANES.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- cmdValid  in  1  command offered.
- cmdReady  out  1  sequencer can accept a command.
- cmdFunction  in  ALUOP  ALU function code, valid 1..10.
- cmdVectorA  in  BITS*LANES  packed operand A; lane i = bits [i*BITS +: BITS].
- cmdVectorB  in  BITS*LANES  packed operand B, same packing.
- cmdScalarB  in  1  when 1, lane 0 of B is broadcast to all lanes.
- cmdLength  in  LENW  number of active lanes, 0..LANES.
- aluFunction  out  ALUOP  function code to ALU.
- aluOperandA  out  BITS  to ALU vectorA.
- aluOperandB  out  BITS  to ALU vectorB.
- aluResult  in  BITS  from ALU; combinational, same-cycle.
- resValid  out  1  result vector available.
- resReady  in  1  consumer accepts result.
- resVector  out  BITS*LANES  packed result.
- resError  out  1  command had an illegal function code or length; qualified by resValid.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (effective on a clk edge with reset=1, from any state, including mid-issue): state=IDLE, laneIdx=0, resVector=0, resError=0, resValid=0, aluFunction=0, aluOperandA=0, aluOperandB=0, busy=0. Any in-flight command is discarded, with no partial result.
- cmdReady = (state==IDLE). A command is accepted on a clock edge where cmdValid && cmdReady.
- On accept:
  - Latch function, A, B, scalar flag and length.
  - Clear resVector to 0 and set laneIdx=0.
  - Error check: if function==0, function>10, or cmdLength>LANES, set resError=1 and go to DONE with resVector=0. No ALU issue.
  - Else if cmdLength==0: set resError=0 and go to DONE; resVector stays 0.
  - Else: set resError=0 and go to ISSUE.
- ISSUE, each cycle:
  - aluFunction = latched function.
  - aluOperandA = A lane laneIdx.
  - aluOperandB = cmdScalarB ? B lane 0 : B lane laneIdx.
  - On the clock edge, aluResult is written to resVector lane laneIdx and laneIdx increments.
  - When laneIdx == length-1 on that edge, go to DONE.
- Outside ISSUE, the alu* outputs are driven to 0. Function 0 yields result 0 at the ALU.
- DONE: resValid=1. resVector and resError are held stable until resReady=1. On resValid && resReady, go to IDLE.
- Lanes at index >= length read 0 in resVector.
- Latency: command accepted at edge T gives lane i issued in cycle T+1+i, and resValid is first high after edge T+length. A length-0 or error command gives resValid high after edge T+1... more precisely, DONE is entered at edge T, so resValid is high in the cycle after T.
- Throughput: a new command can be accepted no earlier than the cycle after the result handshake (IDLE re-entry). There is no overlap.
- cmdValid held while busy is ignored; the command data is not sampled.
- resReady asserted outside DONE has no effect.
- laneIdx never exceeds LANES-1. No wrap occurs, because DONE is entered on the last lane.
- Width rules:
  - The sequencer passes operands unmodified.
  - Shift and rotate amounts come from B lanes unchanged. ALU semantics (masking, rotate amounts outside 1..7 give passthrough) belong to the ALU.

Test Plan:
1. Add, length 4. A lanes3..0 = 04,03,02,01; B = 10,10,10,10; function 2.
   - Required: aluOperandA sequence 01,02,03,04 on 4 consecutive cycles.
   - Required: resVector = 0x14131211; resError=0; resValid in the 4th cycle after accept.
2. Scalar broadcast subtract. function 3, cmdScalarB=1, B lane0 = 01, other B lanes = FF, A = 05,05,05,05.
   - Required: aluOperandB = 01 on every issue cycle.
   - Required: resVector = 0x04040404.
3. Partial length and backpressure. function 6 (Or), length 2, A = AA,AA,F0,0F, B = 0.
   - Required: resVector = 0x0000F00F.
   - Hold resReady=0 for 5 cycles: resValid and resVector stay stable, cmdReady=0; a cmdValid pulse in that window is ignored.
4. Illegal inputs.
   - function 0 with length 4: resError=1, resVector=0, resValid 1 cycle after accept, alu* outputs stay 0.
   - function 11: same response.
   - length 5: same response.
5. Length 0 with function 2: resError=0, resVector=0, no ALU issue cycles.
6. Reset mid-operation. Assert reset at the 3rd issue cycle of a length-4 command.
   - Next cycle: state IDLE, cmdReady=1, resValid=0, resVector=0.
   - A following function-4 (XOR) command with A = FF×4, B = 0F×4 gives 0xF0F0F0F0.

Source files
------------

// File: rtl/vector_alu_sequencer.sv
// Vector ALU sequencer: accepts one packed multi-lane vector command, issues
// it to the scalar ALU one lane per cycle, collects the combinational ALU
// results and presents the assembled vector on a valid/ready result port.
module vector_alu_sequencer #(
  parameter int BITS  = 8,
  parameter int ALUOP = 4,
  parameter int LANES = 4,
  parameter int LENW  = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmdValid,
  output logic                    cmdReady,
  input  logic [ALUOP-1:0]        cmdFunction,
  input  logic [BITS*LANES-1:0]   cmdVectorA,
  input  logic [BITS*LANES-1:0]   cmdVectorB,
  input  logic                    cmdScalarB,
  input  logic [LENW-1:0]         cmdLength,
  output logic [ALUOP-1:0]        aluFunction,
  output logic [BITS-1:0]         aluOperandA,
  output logic [BITS-1:0]         aluOperandB,
  input  logic [BITS-1:0]         aluResult,
  output logic                    resValid,
  input  logic                    resReady,
  output logic [BITS*LANES-1:0]   resVector,
  output logic                    resError,
  output logic                    busy
);

  localparam int VECW = BITS * LANES;
  localparam int IDXW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } stateT;

  stateT            state;
  logic [VECW-1:0]  aReg;
  logic [VECW-1:0]  bReg;
  logic             scalarReg;
  logic [LENW-1:0]  lenReg;
  logic [IDXW-1:0]  laneIdx;

  logic             cmdIllegal;
  logic             lastLane;
  logic [IDXW-1:0]  nextIdx;

  function automatic logic [BITS-1:0] laneOf(input logic [VECW-1:0] vec, input int idx);
    return vec[idx*BITS +: BITS];
  endfunction

  // Decode helpers: command legality, last-lane detection and the next lane index
  assign cmdIllegal = (cmdFunction == '0) || (cmdFunction > ALUOP'(10)) ||
                      (cmdLength > LENW'(LANES));
  assign lastLane   = (LENW'(laneIdx) == (lenReg - LENW'(1)));
  assign nextIdx    = laneIdx + IDXW'(1);
  assign cmdReady   = (state == IDLE);

  // Sequencer FSM; ALU drive is registered so it always presents the lane for laneIdx
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      aReg        <= '0;
      bReg        <= '0;
      scalarReg   <= 1'b0;
      lenReg      <= '0;
      laneIdx     <= '0;
      resVector   <= '0;
      resError    <= 1'b0;
      resValid    <= 1'b0;
      aluFunction <= '0;
      aluOperandA <= '0;
      aluOperandB <= '0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmdValid) begin
            aReg      <= cmdVectorA;
            bReg      <= cmdVectorB;
            scalarReg <= cmdScalarB;
            lenReg    <= cmdLength;
            resVector <= '0;
            laneIdx   <= '0;
            busy      <= 1'b1;
            if (cmdIllegal) begin
              resError <= 1'b1;
              resValid <= 1'b1;
              state    <= DONE;
            end else if (cmdLength == '0) begin
              resError <= 1'b0;
              resValid <= 1'b1;
              state    <= DONE;
            end else begin
              resError    <= 1'b0;
              aluFunction <= cmdFunction;
              aluOperandA <= laneOf(cmdVectorA, 0);
              aluOperandB <= laneOf(cmdVectorB, 0);
              state       <= ISSUE;
            end
          end
        end
        ISSUE: begin
          resVector[int'(laneIdx)*BITS +: BITS] <= aluResult;
          if (lastLane) begin
            aluFunction <= '0;
            aluOperandA <= '0;
            aluOperandB <= '0;
            resValid    <= 1'b1;
            state       <= DONE;
          end else begin
            laneIdx     <= nextIdx;
            aluOperandA <= laneOf(aReg, int'(nextIdx));
            aluOperandB <= scalarReg ? laneOf(bReg, 0) : laneOf(bReg, int'(nextIdx));
          end
        end
        DONE: begin
          if (resReady) begin
            resValid <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_alu_sequencer.sv
// Testbench for vector_alu_sequencer: directed cases plus randomized commands
// checked against a lane-by-lane behavioural model and a stand-in ALU.
module tb_vector_alu_sequencer;

  localparam int BITS  = 8;
  localparam int ALUOP = 4;
  localparam int LANES = 4;
  localparam int LENW  = 3;
  localparam int VECW  = BITS * LANES;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmdValid = 1'b0;
  logic             cmdReady;
  logic [ALUOP-1:0] cmdFunction = '0;
  logic [VECW-1:0]  cmdVectorA = '0;
  logic [VECW-1:0]  cmdVectorB = '0;
  logic             cmdScalarB = 1'b0;
  logic [LENW-1:0]  cmdLength = '0;
  logic [ALUOP-1:0] aluFunction;
  logic [BITS-1:0]  aluOperandA;
  logic [BITS-1:0]  aluOperandB;
  logic [BITS-1:0]  aluResult;
  logic             resValid;
  logic             resReady = 1'b0;
  logic [VECW-1:0]  resVector;
  logic             resError;
  logic             busy;

  int compareCount = 0;
  int failCount    = 0;

  vector_alu_sequencer #(.BITS(BITS), .ALUOP(ALUOP), .LANES(LANES), .LENW(LENW)) dut (
    .clk(clk), .reset(reset),
    .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdFunction(cmdFunction),
    .cmdVectorA(cmdVectorA), .cmdVectorB(cmdVectorB), .cmdScalarB(cmdScalarB),
    .cmdLength(cmdLength),
    .aluFunction(aluFunction), .aluOperandA(aluOperandA), .aluOperandB(aluOperandB),
    .aluResult(aluResult),
    .resValid(resValid), .resReady(resReady), .resVector(resVector),
    .resError(resError), .busy(busy)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Stand-in scalar ALU; function 0 and unknown codes give 0
  function automatic logic [BITS-1:0] aluStub(input logic [ALUOP-1:0] fn,
                                               input logic [BITS-1:0] a,
                                               input logic [BITS-1:0] b);
    case (fn)
      4'd1:    return a;
      4'd2:    return a + b;
      4'd3:    return a - b;
      4'd4:    return a ^ b;
      4'd5:    return a & b;
      4'd6:    return a | b;
      4'd7:    return a << b[2:0];
      4'd8:    return a >> b[2:0];
      4'd9:    return ~a;
      4'd10:   return (a < b) ? 8'd1 : 8'd0;
      default: return '0;
    endcase
  endfunction

  assign aluResult = aluStub(aluFunction, aluOperandA, aluOperandB);

  function automatic logic [BITS-1:0] laneOfVec(input logic [VECW-1:0] v, input int i);
    return v[i*BITS +: BITS];
  endfunction

  // Reference model: legality, then each active lane evaluated on its own
  function automatic bit modelError(input logic [ALUOP-1:0] fn, input logic [LENW-1:0] len);
    return (int'(fn) == 0) || (int'(fn) > 10) || (int'(len) > LANES);
  endfunction

  function automatic logic [BITS-1:0] modelOpB(input logic [VECW-1:0] b, input bit scalar, input int i);
    return scalar ? laneOfVec(b, 0) : laneOfVec(b, i);
  endfunction

  function automatic logic [VECW-1:0] modelVector(input logic [ALUOP-1:0] fn,
                                                   input logic [VECW-1:0] a,
                                                   input logic [VECW-1:0] b,
                                                   input bit scalar,
                                                   input logic [LENW-1:0] len);
    logic [VECW-1:0] r;
    r = '0;
    if (!modelError(fn, len))
      for (int i = 0; i < int'(len); i++)
        r[i*BITS +: BITS] = aluStub(fn, laneOfVec(a, i), modelOpB(b, scalar, i));
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compareCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Offer one command, follow its issue cycles, hold off the result, then handshake
  task automatic applyStimulus(input string name,
                               input logic [ALUOP-1:0] fn,
                               input logic [VECW-1:0] a,
                               input logic [VECW-1:0] b,
                               input bit scalar,
                               input logic [LENW-1:0] len,
                               input int holdCycles,
                               input bit pulseInHold);
    logic [BITS-1:0]  obsA[$];
    logic [BITS-1:0]  obsB[$];
    logic [ALUOP-1:0] obsF[$];
    logic [VECW-1:0]  expVec;
    bit               expErr;
    int               expIssue;
    int               issued;
    expErr   = modelError(fn, len);
    expVec   = modelVector(fn, a, b, scalar, len);
    expIssue = expErr ? 0 : int'(len);

    checkOutput({name, " cmdReady"}, 64'(cmdReady), 64'd1);
    cmdValid    = 1'b1;
    cmdFunction = fn;
    cmdVectorA  = a;
    cmdVectorB  = b;
    cmdScalarB  = scalar;
    cmdLength   = len;
    @(negedge clk);
    cmdValid    = 1'b0;
    cmdFunction = ALUOP'($urandom);
    cmdVectorA  = $urandom;
    cmdVectorB  = $urandom;
    cmdScalarB  = 1'($urandom);
    cmdLength   = LENW'($urandom);

    issued = 0;
    while (!resValid && issued < 20) begin
      obsA.push_back(aluOperandA);
      obsB.push_back(aluOperandB);
      obsF.push_back(aluFunction);
      issued++;
      @(negedge clk);
    end
    checkOutput({name, " issueCycles"}, 64'(issued), 64'(expIssue));
    for (int i = 0; i < issued && i < expIssue; i++) begin
      checkOutput($sformatf("%s opA[%0d]", name, i), 64'(obsA[i]), 64'(laneOfVec(a, i)));
      checkOutput($sformatf("%s opB[%0d]", name, i), 64'(obsB[i]), 64'(modelOpB(b, scalar, i)));
      checkOutput($sformatf("%s fn[%0d]", name, i), 64'(obsF[i]), 64'(fn));
    end

    checkOutput({name, " resValid"}, 64'(resValid), 64'd1);
    checkOutput({name, " resVector"}, 64'(resVector), 64'(expVec));
    checkOutput({name, " resError"}, 64'(resError), 64'(expErr));
    checkOutput({name, " aluIdle"}, {52'd0, aluFunction, aluOperandA, aluOperandB}, 64'd0);
    checkOutput({name, " busyDone"}, {62'd0, busy, cmdReady}, 64'b10);

    for (int h = 0; h < holdCycles; h++) begin
      if (pulseInHold && h == 1) begin
        cmdValid    = 1'b1;
        cmdFunction = 4'd2;
        cmdLength   = 3'd4;
        cmdVectorA  = 32'h5555_5555;
      end
      resReady = 1'($urandom_range(0, 1)) & 1'b0;
      @(negedge clk);
      cmdValid = 1'b0;
      checkOutput($sformatf("%s hold%0d", name, h),
                  {29'd0, resValid, cmdReady, resError, resVector},
                  {29'd0, 1'b1, 1'b0, expErr, expVec});
    end

    resReady = 1'b1;
    @(negedge clk);
    resReady = 1'b0;
    checkOutput({name, " released"}, {61'd0, resValid, cmdReady, busy}, 64'b010);
  endtask

  // Directed scenarios, mid-operation reset, then randomized commands
  initial begin
    logic [ALUOP-1:0] rFn;
    logic [LENW-1:0]  rLen;

    repeat (2) @(negedge clk);
    checkOutput("reset outputs",
                {24'd0, cmdReady, resValid, resError, busy, aluFunction, aluOperandA, aluOperandB},
                {24'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 8'd0});
    checkOutput("reset resVector", 64'(resVector), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    applyStimulus("add4", 4'd2, 32'h04030201, 32'h10101010, 1'b0, 3'd4, 0, 1'b0);
    checkOutput("add4 const", 64'(modelVector(4'd2, 32'h04030201, 32'h10101010, 1'b0, 3'd4)), 64'h14131211);
    applyStimulus("subBcast", 4'd3, 32'h05050505, 32'hFFFFFF01, 1'b1, 3'd4, 0, 1'b0);
    applyStimulus("orLen2", 4'd6, 32'hAAAAF00F, 32'h0, 1'b0, 3'd2, 5, 1'b1);
    applyStimulus("fn0", 4'd0, 32'h12345678, 32'h11111111, 1'b0, 3'd4, 0, 1'b0);
    applyStimulus("fn11", 4'd11, 32'h12345678, 32'h11111111, 1'b0, 3'd4, 0, 1'b0);
    applyStimulus("len5", 4'd2, 32'h12345678, 32'h11111111, 1'b0, 3'd5, 0, 1'b0);
    applyStimulus("len0", 4'd2, 32'h12345678, 32'h11111111, 1'b0, 3'd0, 0, 1'b0);

    cmdValid = 1'b1; cmdFunction = 4'd2; cmdLength = 3'd4;
    cmdVectorA = 32'h01020304; cmdVectorB = 32'h01010101; cmdScalarB = 1'b0;
    @(negedge clk);
    cmdValid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("midReset issue3", {56'd0, aluOperandA}, 64'h02);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midReset state",
                {29'd0, cmdReady, resValid, busy, resVector},
                {29'd0, 1'b1, 1'b0, 1'b0, 32'd0});
    applyStimulus("xorAfterReset", 4'd4, 32'hFFFFFFFF, 32'h0F0F0F0F, 1'b0, 3'd4, 0, 1'b0);
    checkOutput("xor const", 64'(modelVector(4'd4, 32'hFFFFFFFF, 32'h0F0F0F0F, 1'b0, 3'd4)), 64'hF0F0F0F0);

    for (int n = 0; n < 40; n++) begin
      rFn  = ALUOP'($urandom_range(0, 15));
      rLen = ($urandom_range(0, 3) != 0) ? LENW'($urandom_range(1, 4)) : LENW'($urandom_range(0, 7));
      applyStimulus($sformatf("rand%0d", n), rFn, $urandom, $urandom, 1'($urandom_range(0, 1)),
                    rLen, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
